// File: rtl/game_pkg.sv
// Shared game definitions.
// Holds the play-grid geometry, the default candidate budget for food
// placement, and the food placer state encoding. The renderer, the collision
// logic and the food placer all take their grid dimensions from here.
package game_pkg;

  localparam int GRID_W    = 10;  // grid columns, valid x is 0..GRID_W-1
  localparam int GRID_H    = 10;  // grid rows, valid y is 0..GRID_H-1
  localparam int COORD_W   = 4;   // coordinate width in bits
  localparam int MAX_TRIES = 16;  // random candidates before raster fallback

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAND_RD  = 3'd1,
    RAND_CHK = 3'd2,
    SCAN_RD  = 3'd3,
    SCAN_CHK = 3'd4,
    FIN      = 3'd5
  } food_state_t;

endpackage

// File: rtl/grid_scan_counter.sv
// Raster x/y counter over a W x H grid.
// Ports:
//   clk, reset    clock and asynchronous active-high reset (counter -> 0,0)
//   clr           return to (0,0) on the next edge; has priority over adv
//   adv           step to the next cell in raster order (x first, then y)
//   x, y          current cell
//   last          current cell is (W-1, H-1)
// Advancing on the last cell holds position, so the counter never leaves
// the grid. The renderer reuses this block for cell iteration.
module grid_scan_counter #(
  parameter int W  = game_pkg::GRID_W,
  parameter int H  = game_pkg::GRID_H,
  parameter int CW = game_pkg::COORD_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last
);

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;

  assign last = (x_q == CW'(W - 1)) && (y_q == CW'(H - 1));
  assign x    = x_q;
  assign y    = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv && !last) begin
      if (x_q == CW'(W - 1)) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/food_placer.sv
// Food placer: picks a free grid cell for the next food item.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req                   start a placement (only honoured in IDLE)
//   rnd_x, rnd_y          free-running random candidate from the LFSR
//   occ_rd_en/occ_x/occ_y occupancy read request (registered)
//   occ_data              occupancy answer, 1 = occupied
//   busy                  high whenever not IDLE
//   food_x/food_y         placed cell, held until the next accepted req
//   food_valid            food_x/food_y hold a placed cell
//   done, grid_full       single-cycle result pulses
// Random candidates are tried first; after MAX_TRIES rejections a raster
// scan from (0,0) guarantees termination. All outputs are registered.
module food_placer #(
  parameter int GRID_W    = game_pkg::GRID_W,
  parameter int GRID_H    = game_pkg::GRID_H,
  parameter int COORD_W   = game_pkg::COORD_W,
  parameter int MAX_TRIES = game_pkg::MAX_TRIES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [COORD_W-1:0] rnd_x,
  input  logic [COORD_W-1:0] rnd_y,
  output logic               occ_rd_en,
  output logic [COORD_W-1:0] occ_x,
  output logic [COORD_W-1:0] occ_y,
  input  logic               occ_data,
  output logic               busy,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               done,
  output logic               grid_full
);

  import game_pkg::food_state_t;
  import game_pkg::IDLE;
  import game_pkg::RAND_RD;
  import game_pkg::RAND_CHK;
  import game_pkg::SCAN_RD;
  import game_pkg::SCAN_CHK;
  import game_pkg::FIN;

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  food_state_t        state_q, state_d;
  logic [TRIES_W-1:0] tries_q, tries_d, tries_inc;
  logic               chk_wait_q, chk_wait_d;
  logic               occ_rd_en_q, occ_rd_en_d;
  logic [COORD_W-1:0] occ_x_q, occ_x_d, occ_y_q, occ_y_d;
  logic [COORD_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
  logic               busy_q, busy_d;
  logic               food_valid_q, food_valid_d;
  logic               done_q, done_d;
  logic               grid_full_q, grid_full_d;

  logic               scan_clr, scan_adv, scan_last;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic               rnd_in_grid, tries_exhausted, reject;

  grid_scan_counter #(.W(GRID_W), .H(GRID_H), .CW(COORD_W)) u_scan (
    .clk   (clk),
    .reset (reset),
    .clr   (scan_clr),
    .adv   (scan_adv),
    .x     (scan_x),
    .y     (scan_y),
    .last  (scan_last)
  );

  assign rnd_in_grid     = (rnd_x < COORD_W'(GRID_W)) && (rnd_y < COORD_W'(GRID_H));
  assign tries_inc       = tries_q + 1'b1;
  assign tries_exhausted = (tries_inc == TRIES_W'(MAX_TRIES));

  // The read request is registered, so the occupancy RAM sees the address
  // one cycle after the *_RD state and answers one cycle later still. Each
  // *_CHK state therefore spends a first cycle waiting (chk_wait) and decides
  // on the second, which puts done at req edge + 3 for a free first candidate.
  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    chk_wait_d   = chk_wait_q;
    occ_rd_en_d  = 1'b0;
    occ_x_d      = occ_x_q;
    occ_y_d      = occ_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    done_d       = 1'b0;
    grid_full_d  = 1'b0;
    scan_clr     = 1'b0;
    scan_adv     = 1'b0;
    reject       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d      = RAND_RD;
          tries_d      = '0;
          food_valid_d = 1'b0;
        end
      end
      RAND_RD: begin
        if (rnd_in_grid) begin
          occ_rd_en_d = 1'b1;
          occ_x_d     = rnd_x;
          occ_y_d     = rnd_y;
          chk_wait_d  = 1'b1;
          state_d     = RAND_CHK;
        end else begin
          reject = 1'b1;  // off-grid candidate: rejected without a read
        end
      end
      RAND_CHK: begin
        if (chk_wait_q) begin
          chk_wait_d = 1'b0;
        end else if (!occ_data) begin
          food_x_d     = occ_x_q;
          food_y_d     = occ_y_q;
          food_valid_d = 1'b1;
          done_d       = 1'b1;
          state_d      = FIN;
        end else begin
          reject = 1'b1;
        end
      end
      SCAN_RD: begin
        occ_rd_en_d = 1'b1;
        occ_x_d     = scan_x;
        occ_y_d     = scan_y;
        chk_wait_d  = 1'b1;
        state_d     = SCAN_CHK;
      end
      SCAN_CHK: begin
        if (chk_wait_q) begin
          chk_wait_d = 1'b0;
        end else if (!occ_data) begin
          food_x_d     = occ_x_q;
          food_y_d     = occ_y_q;
          food_valid_d = 1'b1;
          done_d       = 1'b1;
          state_d      = FIN;
        end else if (scan_last) begin
          grid_full_d = 1'b1;
          state_d     = FIN;
        end else begin
          scan_adv = 1'b1;
          state_d  = SCAN_RD;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A rejected random candidate either retries or starts the scan at (0,0).
    if (reject) begin
      tries_d = tries_inc;
      if (tries_exhausted) begin
        scan_clr = 1'b1;
        state_d  = SCAN_RD;
      end else begin
        state_d = RAND_RD;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tries_q      <= '0;
      chk_wait_q   <= 1'b0;
      occ_rd_en_q  <= 1'b0;
      occ_x_q      <= '0;
      occ_y_q      <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      busy_q       <= 1'b0;
      food_valid_q <= 1'b0;
      done_q       <= 1'b0;
      grid_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      chk_wait_q   <= chk_wait_d;
      occ_rd_en_q  <= occ_rd_en_d;
      occ_x_q      <= occ_x_d;
      occ_y_q      <= occ_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      busy_q       <= busy_d;
      food_valid_q <= food_valid_d;
      done_q       <= done_d;
      grid_full_q  <= grid_full_d;
    end
  end

  assign occ_rd_en  = occ_rd_en_q;
  assign occ_x      = occ_x_q;
  assign occ_y      = occ_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign busy       = busy_q;
  assign food_valid = food_valid_q;
  assign done       = done_q;
  assign grid_full  = grid_full_q;

endmodule
